// File: rtl/function_unit_pkg.sv
// Shared definitions for the function_unit register-read/execute slice.
// Contents: datapath width, register-file geometry, FS opcode encodings
// ({funct3, funct7[5]}), ZCNV flag bit positions and an FS decode helper.
package function_unit_pkg;

  localparam int XLEN     = 32;
  localparam int NUM_REGS = 32;
  localparam int REG_AW   = 5;

  // Flag vector layout: {Z, C, N, V}
  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [3:0] {
    FS_ADD  = 4'b0000,
    FS_SUB  = 4'b0001,
    FS_SLL  = 4'b0010,
    FS_SLT  = 4'b0100,
    FS_SLTU = 4'b0110,
    FS_XOR  = 4'b1000,
    FS_SRL  = 4'b1010,
    FS_SRA  = 4'b1011,
    FS_OR   = 4'b1100,
    FS_AND  = 4'b1110
  } fs_e;

  // The alt bit only matters for funct3 000 (ADD/SUB) and 101 (SRL/SRA);
  // clearing it elsewhere maps every 4-bit FS onto exactly one opcode.
  function automatic fs_e fs_canon(input logic [3:0] fs);
    logic [3:0] canon_v;
    if ((fs[3:1] == 3'b000) || (fs[3:1] == 3'b101)) begin
      canon_v = fs;
    end else begin
      canon_v = {fs[3:1], 1'b0};
    end
    return fs_e'(canon_v);
  endfunction

endpackage

// File: rtl/function_unit_if.sv
// Bus bundle for function_unit.
// slave  : the function unit (takes ID/WB inputs, drives read data and EX results)
// master : the driver of the ID/WB side (testbench or surrounding pipeline)
// Signals: rd_addr0/rd_addr1 (rs1/rs2), wr_addr0/wr_din0/we0 (WB write),
//          fs_id (operation select), rd_dout0/rd_dout1 (combinational reads),
//          a_ex/b_ex (EX operands), S (ALU result), ZCNVFlags ({Z,C,N,V}).
interface function_unit_if;
  import function_unit_pkg::*;

  logic [REG_AW-1:0] rd_addr0;
  logic [REG_AW-1:0] rd_addr1;
  logic [REG_AW-1:0] wr_addr0;
  logic [XLEN-1:0]   wr_din0;
  logic              we0;
  logic [3:0]        fs_id;
  logic [XLEN-1:0]   rd_dout0;
  logic [XLEN-1:0]   rd_dout1;
  logic [XLEN-1:0]   a_ex;
  logic [XLEN-1:0]   b_ex;
  logic [XLEN-1:0]   S;
  logic [3:0]        ZCNVFlags;

  modport master (
    output rd_addr0, rd_addr1, wr_addr0, wr_din0, we0, fs_id,
    input  rd_dout0, rd_dout1, a_ex, b_ex, S, ZCNVFlags
  );

  modport slave (
    input  rd_addr0, rd_addr1, wr_addr0, wr_din0, we0, fs_id,
    output rd_dout0, rd_dout1, a_ex, b_ex, S, ZCNVFlags
  );

endinterface

// File: rtl/function_unit_pipe_stage_reg.sv
// Generic pipeline register: captures d_i into q_o on every rising edge,
// cleared asynchronously by rst. No enable, no flush.
// Ports: clk, rst, d_i [WIDTH], q_o [WIDTH].
module pipe_stage_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q;

  // Stage register with asynchronous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= {WIDTH{1'b0}};
    end else begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/function_unit_reg_bank.sv
// 32 x XLEN integer register file: two combinational read ports, one
// synchronous write port, x0 hard-wired to zero, and write-through bypass
// so a WB write is visible to an ID read of the same register in the same cycle.
// Ports: clk, rst, rd_addr0_i/rd_addr1_i, wr_addr0_i, wr_din0_i, we0_i,
//        rd_dout0_o/rd_dout1_o.
module reg_bank
  import function_unit_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] rd_addr0_i,
  input  logic [REG_AW-1:0] rd_addr1_i,
  input  logic [REG_AW-1:0] wr_addr0_i,
  input  logic [XLEN-1:0]   wr_din0_i,
  input  logic              we0_i,
  output logic [XLEN-1:0]   rd_dout0_o,
  output logic [XLEN-1:0]   rd_dout1_o
);

  logic [XLEN-1:0] mem_q [NUM_REGS];
  logic            wr_live_s;
  logic [XLEN-1:0] rd0_s;
  logic [XLEN-1:0] rd1_s;

  // A write to x0 is discarded, so it must neither store nor bypass
  assign wr_live_s = we0_i && (wr_addr0_i != 5'd0);

  // Storage update: async clear of every entry, then WB-port writes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem_q[i] <= {XLEN{1'b0}};
      end
    end else begin
      if (wr_live_s) begin
        mem_q[wr_addr0_i] <= wr_din0_i;
      end
    end
  end

  // Read port 0 with x0 forcing and write-through bypass
  always_comb begin
    rd0_s = {XLEN{1'b0}};
    if (rd_addr0_i == 5'd0) begin
      rd0_s = {XLEN{1'b0}};
    end else if (wr_live_s && (wr_addr0_i == rd_addr0_i)) begin
      rd0_s = wr_din0_i;
    end else begin
      rd0_s = mem_q[rd_addr0_i];
    end
  end

  // Read port 1 with x0 forcing and write-through bypass
  always_comb begin
    rd1_s = {XLEN{1'b0}};
    if (rd_addr1_i == 5'd0) begin
      rd1_s = {XLEN{1'b0}};
    end else if (wr_live_s && (wr_addr0_i == rd_addr1_i)) begin
      rd1_s = wr_din0_i;
    end else begin
      rd1_s = mem_q[rd_addr1_i];
    end
  end

  assign rd_dout0_o = rd0_s;
  assign rd_dout1_o = rd1_s;

endmodule

// File: rtl/function_unit.sv
// RV32I register-read + execute slice.
// ID: register file read (combinational, with WB bypass).
// ID/EX: rs1, rs2 and FS registered every cycle.
// EX: combinational ALU producing S and {Z,C,N,V} from the EX registers,
//     so results appear one clock after the addresses/fs_id are presented.
// Ports: clk, rst (async, active-high), bus (function_unit_if.slave).
module function_unit
  import function_unit_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  function_unit_if.slave bus
);

  logic [XLEN-1:0] rd0_s;
  logic [XLEN-1:0] rd1_s;
  logic [XLEN-1:0] a_ex_q;
  logic [XLEN-1:0] b_ex_q;
  logic [3:0]      fs_ex_q;
  logic [XLEN:0]   add_sum_s;
  logic [XLEN:0]   sub_sum_s;
  logic [XLEN-1:0] alu_s;
  logic            carry_s;
  logic            ovf_s;
  logic [3:0]      flags_s;

  reg_bank u_reg_bank (
    .clk        (clk),
    .rst        (rst),
    .rd_addr0_i (bus.rd_addr0),
    .rd_addr1_i (bus.rd_addr1),
    .wr_addr0_i (bus.wr_addr0),
    .wr_din0_i  (bus.wr_din0),
    .we0_i      (bus.we0),
    .rd_dout0_o (rd0_s),
    .rd_dout1_o (rd1_s)
  );

  pipe_stage_reg #(.WIDTH(XLEN)) u_a_ex (
    .clk (clk), .rst (rst), .d_i (rd0_s), .q_o (a_ex_q)
  );

  pipe_stage_reg #(.WIDTH(XLEN)) u_b_ex (
    .clk (clk), .rst (rst), .d_i (rd1_s), .q_o (b_ex_q)
  );

  pipe_stage_reg #(.WIDTH(4)) u_fs_ex (
    .clk (clk), .rst (rst), .d_i (bus.fs_id), .q_o (fs_ex_q)
  );

  // 33-bit sums expose the carry out; SUB is A + ~B + 1 so C=1 means no borrow
  assign add_sum_s = {1'b0, a_ex_q} + {1'b0, b_ex_q};
  assign sub_sum_s = {1'b0, a_ex_q} + {1'b0, ~b_ex_q} + 33'd1;

  // ALU result plus carry/overflow for the arithmetic ops
  always_comb begin
    alu_s   = {XLEN{1'b0}};
    carry_s = 1'b0;
    ovf_s   = 1'b0;
    case (fs_canon(fs_ex_q))
      FS_ADD: begin
        alu_s   = add_sum_s[XLEN-1:0];
        carry_s = add_sum_s[XLEN];
        ovf_s   = (a_ex_q[XLEN-1] == b_ex_q[XLEN-1]) &&
                  (add_sum_s[XLEN-1] != a_ex_q[XLEN-1]);
      end
      FS_SUB: begin
        alu_s   = sub_sum_s[XLEN-1:0];
        carry_s = sub_sum_s[XLEN];
        ovf_s   = (a_ex_q[XLEN-1] != b_ex_q[XLEN-1]) &&
                  (sub_sum_s[XLEN-1] != a_ex_q[XLEN-1]);
      end
      FS_SLL:  alu_s = a_ex_q << b_ex_q[4:0];
      FS_SLT:  alu_s = {31'd0, ($signed(a_ex_q) < $signed(b_ex_q))};
      FS_SLTU: alu_s = {31'd0, (a_ex_q < b_ex_q)};
      FS_XOR:  alu_s = a_ex_q ^ b_ex_q;
      FS_SRL:  alu_s = a_ex_q >> b_ex_q[4:0];
      FS_SRA:  alu_s = $unsigned($signed(a_ex_q) >>> b_ex_q[4:0]);
      FS_OR:   alu_s = a_ex_q | b_ex_q;
      FS_AND:  alu_s = a_ex_q & b_ex_q;
      default: begin
        alu_s   = {XLEN{1'b0}};
        carry_s = 1'b0;
        ovf_s   = 1'b0;
      end
    endcase
  end

  // Flag assembly; Z and N apply to every op
  always_comb begin
    flags_s         = 4'b0000;
    flags_s[FLAG_Z] = (alu_s == {XLEN{1'b0}});
    flags_s[FLAG_C] = carry_s;
    flags_s[FLAG_N] = alu_s[XLEN-1];
    flags_s[FLAG_V] = ovf_s;
  end

  assign bus.rd_dout0  = rd0_s;
  assign bus.rd_dout1  = rd1_s;
  assign bus.a_ex      = a_ex_q;
  assign bus.b_ex      = b_ex_q;
  assign bus.S         = alu_s;
  assign bus.ZCNVFlags = flags_s;

endmodule

// File: tb/tb_function_unit.sv
// Scoreboard bench for function_unit: the stimulus process issues one
// operation per cycle and pushes the expected EX-stage response; a monitor
// pops and compares one clock later, on the falling edge.
module tb_function_unit;
  import function_unit_pkg::*;

  typedef struct {
    logic [31:0] s;
    logic [3:0]  f;
    logic [31:0] a;
    logic [31:0] b;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  function_unit_if bus ();

  function_unit dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  exp_t exp_q[$];
  logic issue_v = 1'b0;
  logic vld_ex = 1'b0;

  logic [31:0] model_regs [32];
  logic [31:0] cur_a, cur_b;
  logic [31:0] specials [5] = '{32'h0000_0000, 32'h0000_0001, 32'h7FFF_FFFF,
                                32'h8000_0000, 32'hFFFF_FFFF};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference ALU from the instruction semantics, using wide integer arithmetic
  function automatic void ref_alu(input logic [3:0] fs, input logic [31:0] a,
                                  input logic [31:0] b, output logic [31:0] s,
                                  output logic [3:0] f);
    longint sr;
    longint unsigned ur;
    logic c, v;
    int sh;
    c = 1'b0; v = 1'b0; s = 32'd0; sh = int'(b[4:0]);
    case (fs[3:1])
      3'd0: begin
        if (fs[0] == 1'b0) begin
          ur = longint'(a) + longint'(b);
          s  = ur[31:0];
          c  = ur[32];
          sr = longint'(int'(a)) + longint'(int'(b));
        end else begin
          s  = a - b;
          c  = (a >= b);
          sr = longint'(int'(a)) - longint'(int'(b));
        end
        v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      3'd1: s = a << sh;
      3'd2: s = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      3'd3: s = (a < b) ? 32'd1 : 32'd0;
      3'd4: s = a ^ b;
      3'd5: s = fs[0] ? 32'(int'(a) >>> sh) : (a >> sh);
      3'd6: s = a | b;
      default: s = a & b;
    endcase
    f = {(s == 32'd0), c, s[31], v};
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] addr);
    if (addr == 5'd0) return 32'd0;
    if (bus.we0 && bus.wr_addr0 == addr) return bus.wr_din0;
    return model_regs[addr];
  endfunction

  // Present one cycle of ID/WB inputs; model reads are taken before the write lands
  task automatic cyc_drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                           input logic [4:0] r0, input logic [4:0] r1, input logic [3:0] fs);
    @(posedge clk);
    #1;
    issue_v      = 1'b0;
    bus.we0      = we;
    bus.wr_addr0 = wa;
    bus.wr_din0  = wd;
    bus.rd_addr0 = r0;
    bus.rd_addr1 = r1;
    bus.fs_id    = fs;
    cur_a = model_read(r0);
    cur_b = model_read(r1);
    if (we && wa != 5'd0) model_regs[wa] = wd;
  endtask

  task automatic push_exp(input logic [31:0] s, input logic [3:0] f);
    exp_t e;
    e.s = s; e.f = f; e.a = cur_a; e.b = cur_b;
    exp_q.push_back(e);
    issue_v = 1'b1;
  endtask

  task automatic push_model();
    logic [31:0] s;
    logic [3:0] f;
    ref_alu(bus.fs_id, cur_a, cur_b, s, f);
    push_exp(s, f);
  endtask

  // Delay the issue marker by one clock to line up with the EX registers
  always @(posedge clk) vld_ex <= issue_v;

  // Monitor: compare the EX outputs against the oldest expected entry
  always @(negedge clk) begin
    if (vld_ex) begin
      if (exp_q.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("S", bus.S, e.s);
        check("ZCNV", {28'd0, bus.ZCNVFlags}, {28'd0, e.f});
        check("a_ex", bus.a_ex, e.a);
        check("b_ex", bus.b_ex, e.b);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
    bus.we0 = 1'b0; bus.wr_addr0 = 5'd0; bus.wr_din0 = 32'd0;
    bus.rd_addr0 = 5'd0; bus.rd_addr1 = 5'd0; bus.fs_id = 4'd0;
    cur_a = 32'd0; cur_b = 32'd0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_a_ex", bus.a_ex, 32'd0);
    check("rst_b_ex", bus.b_ex, 32'd0);
    check("rst_S", bus.S, 32'd0);
    check("rst_flags", {28'd0, bus.ZCNVFlags}, 32'h8);
    rst = 1'b0;

    // Directed arithmetic
    cyc_drive(1'b1, 5'd5, 32'h7, 5'd0, 5'd0, FS_ADD);
    cyc_drive(1'b1, 5'd6, 32'h3, 5'd0, 5'd0, FS_ADD);
    cyc_drive(1'b0, 5'd0, 32'd0, 5'd5, 5'd6, FS_ADD); push_exp(32'h0000_000A, 4'b0000);
    cyc_drive(1'b0, 5'd0, 32'd0, 5'd5, 5'd6, FS_SUB); push_exp(32'h0000_0004, 4'b0100);
    cyc_drive(1'b0, 5'd0, 32'd0, 5'd6, 5'd5, FS_SUB); push_exp(32'hFFFF_FFFC, 4'b0010);
    cyc_drive(1'b1, 5'd7, 32'h7FFF_FFFF, 5'd0, 5'd0, FS_ADD);
    cyc_drive(1'b1, 5'd8, 32'h1, 5'd0, 5'd0, FS_ADD);
    cyc_drive(1'b0, 5'd0, 32'd0, 5'd7, 5'd8, FS_ADD); push_exp(32'h8000_0000, 4'b0011);
    cyc_drive(1'b0, 5'd0, 32'd0, 5'd5, 5'd5, FS_SUB); push_exp(32'h0000_0000, 4'b1100);

    // Shifts and compares
    cyc_drive(1'b1, 5'd10, 32'h8000_0000, 5'd0, 5'd0, FS_ADD);
    cyc_drive(1'b1, 5'd11, 32'h24, 5'd0, 5'd0, FS_ADD);
    cyc_drive(1'b1, 5'd12, 32'hFFFF_FFFF, 5'd0, 5'd0, FS_ADD);
    cyc_drive(1'b1, 5'd13, 32'h1, 5'd10, 5'd11, FS_SRA); push_exp(32'hF800_0000, 4'b0010);
    cyc_drive(1'b0, 5'd0, 32'd0, 5'd10, 5'd11, FS_SRL); push_exp(32'h0800_0000, 4'b0000);
    cyc_drive(1'b0, 5'd0, 32'd0, 5'd12, 5'd13, FS_SLT); push_exp(32'h0000_0001, 4'b0000);
    cyc_drive(1'b0, 5'd0, 32'd0, 5'd12, 5'd13, FS_SLTU); push_exp(32'h0000_0000, 4'b1000);

    // x0 is immune to writes, including through the bypass
    cyc_drive(1'b1, 5'd0, 32'hDEAD_BEEF, 5'd0, 5'd0, FS_ADD); push_exp(32'd0, 4'b1000);
    #1 check("x0_bypass", bus.rd_dout0, 32'd0);
    cyc_drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, FS_ADD); push_exp(32'd0, 4'b1000);

    // Same-cycle write/read bypass, then the stored value
    cyc_drive(1'b1, 5'd9, 32'h1234, 5'd9, 5'd0, FS_ADD); push_exp(32'h1234, 4'b0000);
    #1 check("x9_bypass", bus.rd_dout0, 32'h1234);
    cyc_drive(1'b0, 5'd0, 32'd0, 5'd9, 5'd9, FS_XOR); push_exp(32'd0, 4'b1000);

    // Randomized traffic against the reference model
    for (int n = 0; n < 400; n++) begin
      logic [4:0] wa, r0, r1;
      logic [31:0] wd;
      wa = 5'($urandom_range(31, 0));
      wd = ($urandom_range(3, 0) == 0) ? specials[$urandom_range(4, 0)] : $urandom;
      r0 = ($urandom_range(3, 0) == 0) ? wa : 5'($urandom_range(31, 0));
      r1 = ($urandom_range(3, 0) == 0) ? wa : 5'($urandom_range(31, 0));
      cyc_drive(1'($urandom_range(1, 0)), wa, wd, r0, r1, 4'($urandom_range(15, 0)));
      push_model();
    end

    // Mid-run reset
    cyc_drive(1'b0, 5'd0, 32'd0, 5'd7, 5'd8, FS_ADD);
    cyc_drive(1'b0, 5'd0, 32'd0, 5'd7, 5'd8, FS_ADD);
    @(negedge clk);
    rst = 1'b1;
    #2;
    check("mid_rst_a_ex", bus.a_ex, 32'd0);
    check("mid_rst_b_ex", bus.b_ex, 32'd0);
    check("mid_rst_S", bus.S, 32'd0);
    check("mid_rst_flags", {28'd0, bus.ZCNVFlags}, 32'h8);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;

    for (int i = 0; i < 32; i++) begin
      cyc_drive(1'b0, 5'd0, 32'd0, 5'(i), 5'(31 - i), FS_OR);
      push_model();
      #1;
      check("post_rst_rd0", bus.rd_dout0, 32'd0);
      check("post_rst_rd1", bus.rd_dout1, 32'd0);
    end

    for (int n = 0; n < 100; n++) begin
      logic [4:0] wa;
      wa = 5'($urandom_range(31, 0));
      cyc_drive(1'($urandom_range(1, 0)), wa, $urandom, 5'($urandom_range(31, 0)),
                wa, 4'($urandom_range(15, 0)));
      push_model();
    end

    cyc_drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, FS_ADD);
    cyc_drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, FS_ADD);
    @(negedge clk);
    check("drain", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/function_unit.md
Name: function_unit

Overview:
- Register-read plus execute slice of the RV32I 5-stage core.
- Holds the 32x32 integer register file with two combinational read ports and one synchronous write port.
- The two read operands and the operation select are registered across the ID/EX boundary.
- A combinational 32-bit ALU then produces the result S and the ZCNV flags used for branch resolution.

Parameters:
- XLEN, 32, datapath width (fixed at 32 for RV32I; other values not required to work).

Ports:
- clk  in  1  single clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- rd_addr0  in  5  rs1 address (ID stage).
- rd_addr1  in  5  rs2 address (ID stage).
- wr_addr0  in  5  rd address (WB stage).
- wr_din0  in  32  write data (WB stage).
- we0  in  1  write enable.
- fs_id  in  4  operation select, ID stage; encoded {funct3, funct7[5]}.
- rd_dout0  out  32  rs1 read data, combinational (ID).
- rd_dout1  out  32  rs2 read data, combinational (ID).
- a_ex  out  32  registered rs1 operand (EX).
- b_ex  out  32  registered rs2 operand (EX).
- S  out  32  ALU result computed from a_ex, b_ex and the registered FS.
- ZCNVFlags  out  4  bit3 Z, bit2 C, bit1 N, bit0 V.

Behaviour:
- Register file storage:
  - 32 entries of 32 bits.
  - Async reset clears all entries to 0.
  - x0 always reads 0; writes to x0 are ignored.
- Register file write: on posedge clk with we0=1 and wr_addr0!=0, entry[wr_addr0] <= wr_din0.
- Register file read:
  - Combinational.
  - Internal write-through bypass: if we0=1, wr_addr0!=0 and wr_addr0 equals a read address, that port returns wr_din0 in the same cycle. This covers the WB-to-ID hazard.
- Pipeline registers:
  - a_ex, b_ex and FS_ex load rd_dout0, rd_dout1 and fs_id on every posedge clk.
  - No enable and no flush.
  - Async reset drives them to 0.
- Latency:
  - S and ZCNVFlags are combinational from the EX registers.
  - They become valid one clock after the addresses and fs_id are presented.
- FS decode (FS[3:1]=funct3, FS[0]=alt):
  - 000/0: ADD A+B.
  - 000/1: SUB A-B.
  - 001: SLL A<<B[4:0].
  - 010: SLT, signed A<B -> 1 else 0.
  - 011: SLTU, unsigned compare.
  - 100: XOR.
  - 101/0: SRL (logical).
  - 101/1: SRA (arithmetic).
  - 110: OR.
  - 111: AND.
  - FS[0] is ignored for all other funct3 values.
  - Shift amounts use only B[4:0].
- Flags:
  - Z = (S==0) for every op.
  - N = S[31] for every op.
  - ADD:
    - C = carry out of bit 31.
    - V = signed overflow, i.e. A[31]==B[31] and S[31]!=A[31].
  - SUB (computed as A + ~B + 1):
    - C = carry out, so 1 means no borrow (A>=B unsigned).
    - V = A[31]!=B[31] and S[31]!=A[31].
  - All logic, shift and compare ops: C=0, V=0.
- Reset mid-operation: the EX registers clear immediately, so S=0 (ADD 0+0) and ZCNVFlags=4'b1000 while reset is held.
- Simultaneous events:
  - A write and a read of the same address in one cycle: the read returns the new data via bypass, and that value is captured into the EX register at the edge.

Decomposition:
- Shared package holds:
  - the FS opcode constants (FS_ADD=0000, FS_SUB=0001, FS_SLL=0010, FS_SLT=0100, FS_SLTU=0110, FS_XOR=1000, FS_SRL=1010, FS_SRA=1011, FS_OR=1100, FS_AND=1110);
  - the flag bit indices;
  - XLEN.
- Two sub-modules are natural:
  - pipe_stage_reg: WIDTH parameter, D->Q on posedge, async clear.
  - reg_bank: 32x32 storage with the bypass.
- The ALU is an always_comb block in the top.

Test Plan:
- Write x5=0x0000_0007 and x6=0x0000_0003, then read rs1=5, rs2=6 with fs_id=0000 -> next cycle S=0x0000_000A, flags=0000.
- Same operands with fs_id=0001 (SUB) -> S=4, C=1, Z=0. Then swap operands -> S=0xFFFF_FFFC, N=1, C=0.
- ADD 0x7FFF_FFFF + 1 -> S=0x8000_0000, N=1, V=1, C=0. SUB 5-5 -> S=0, Z=1, C=1.
- SRA 0x8000_0000 by B=0x24 (shift 4) -> S=0xF800_0000. SRL gives 0x0800_0000. SLT of -1 vs 1 -> 1, SLTU -> 0.
- Write x0=0xDEAD_BEEF, then read x0 -> 0. Same-cycle write x9=0x1234 and read x9 -> rd_dout0=0x1234 immediately.
- Assert rst mid-run -> a_ex=b_ex=0, S=0, ZCNVFlags=4'b1000, all registers read 0 after release.
